// File: rtl/systolic_input_skewer.sv
// Systolic array row feeder: delays lane i of each accepted column by i advances, then drains and pulses done.
// Optional macro SKEW_REVERSE_EN gives lane i N-i stages instead, for row-reversed arrays.
module systolic_input_skewer #(
  parameter int N      = 4,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               adv;
  logic               accept;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready.
  // in_ready already folds in out_ready, so a stalled array never accepts.
  assign adv      = out_ready;
  assign in_ready = out_ready && (state_q != S_DRAIN) && rst_n;
  assign accept   = in_valid && in_ready;

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          if (in_last) begin
            if (N > 1) begin
              state_d = S_DRAIN;
              cnt_d   = CNT_W'(N - 1);
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_DRAIN: begin
        // The last column reaches the deepest lane on the advance that empties the counter.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (adv) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
`ifdef SKEW_REVERSE_EN
    localparam int DEPTH = N - i;
`else
    localparam int DEPTH = i + 1;
`endif
    logic [DEPTH-1:0]  v_q;
    logic [DATA_W-1:0] d_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int s = 0; s < DEPTH; s++) d_q[s] <= '0;
      end else if (adv) begin
        v_q[0] <= accept;
        d_q[0] <= accept ? in_data[i*DATA_W +: DATA_W] : '0;
        for (int s = 1; s < DEPTH; s++) begin
          v_q[s] <= v_q[s-1];
          d_q[s] <= d_q[s-1];
        end
      end
    end

    assign out_valid[i]                   = v_q[DEPTH-1];
    assign out_data[i*DATA_W +: DATA_W]   = v_q[DEPTH-1] ? d_q[DEPTH-1] : '0;
  end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Scoreboard bench for systolic_input_skewer: directed tiles, stall, single column, back-to-back, reset mid-tile.
module tb_systolic_input_skewer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [N-1:0] out_valid;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  systolic_input_skewer #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_data(in_data), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int adv_edges = 0;

  // {data, advancing edge after which the lane must present it}
  logic [DW+31:0] exp_q [N][$];
  logic [31:0]    done_q [$];

  always @(posedge clk) if (rst_n && out_ready) adv_edges <= adv_edges + 1;

  function automatic int skew(input int i);
`ifdef SKEW_REVERSE_EN
    return N - 1 - i;
`else
    return i;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic flush_exp();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    done_q.delete();
  endtask

  // monitor: pops one entry per lane each advancing cycle in which the lane is valid
  always @(negedge clk) begin
    logic [DW+31:0] ent;
    logic [DW-1:0]  got;
    if (rst_n && out_ready) begin
      for (int i = 0; i < N; i++) begin
        got = out_data[i*DW +: DW];
        if (out_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("lane%0d_unexpected_valid", i), 64'(out_valid[i]), 64'd0);
          end else begin
            ent = exp_q[i].pop_front();
            chk($sformatf("lane%0d_data", i), 64'(got), 64'(ent[DW+31:32]));
            chk($sformatf("lane%0d_edge", i), 64'(adv_edges), 64'(ent[31:0]));
          end
        end else begin
          chk($sformatf("lane%0d_zero_when_invalid", i), 64'(got), 64'd0);
          if (exp_q[i].size() > 0 && exp_q[i][0][31:0] == 32'(adv_edges))
            chk($sformatf("lane%0d_missing", i), 64'(out_valid[i]), 64'd1);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else chk("done_edge", 64'(adv_edges), 64'(done_q.pop_front()));
      end else if (done_q.size() > 0 && done_q[0] == 32'(adv_edges)) begin
        chk("done_missing", 64'(done), 64'd1);
      end
    end
  end

  // driver: offers one beat, optionally stalling the array first; returns cycles spent waiting
  task automatic send_beat(input logic [W-1:0] d, input logic last, input int stall_n,
                           output int waited, output logic done_acc);
    logic [W-1:0] snap_d;
    logic [N-1:0] snap_v;
    logic         snap_done;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (stall_n > 0) begin
      out_ready = 1'b0;
      @(negedge clk);
      snap_d = out_data; snap_v = out_valid; snap_done = done;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      for (int s = 1; s < stall_n; s++) begin
        @(negedge clk);
        chk("stall_data_hold", 64'(out_data), 64'(snap_d));
        chk("stall_valid_hold", 64'(out_valid), 64'(snap_v));
        chk("stall_done_hold", 64'(done), 64'(snap_done));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
    end
    waited = 0;
    done_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 60) begin
        chk("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    done_acc = done;
    for (int i = 0; i < N; i++)
      exp_q[i].push_back({d[i*DW +: DW], 32'(adv_edges + 1 + skew(i))});
    if (last) done_q.push_back(32'(adv_edges + 1 + N - 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // column k, lane i = base + (i*4 + k + 1) * 0x0100
  function automatic logic [W-1:0] col(input logic [DW-1:0] base, input int k);
    logic [W-1:0] c;
    for (int i = 0; i < N; i++) c[i*DW +: DW] = base + DW'((i * 4 + k + 1) * 256);
    return c;
  endfunction

  task automatic send_tile(input logic [DW-1:0] base, input int stall_col, input int stall_n,
                           output int first_wait, output logic first_done);
    int   w;
    logic dacc;
    for (int k = 0; k < 4; k++) begin
      send_beat(col(base, k), k == 3, (k == stall_col) ? stall_n : 0, w, dacc);
      if (k == 0) begin
        first_wait = w;
        first_done = dacc;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (!busy && done_q.size() == 0 && exp_q[N-1].size() == 0 && exp_q[0].size() == 0) break;
      t++;
    end
    if (t >= 100) chk("idle_timeout", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] stair [7];
  int           fw;
  logic         fd;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SKEW_REVERSE_EN
    stair = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
`else
    stair = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
`endif
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single tile with explicit staircase
    fork
      send_tile(16'h0000, -1, 0, fw, fd);
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (out_valid == '0 && t < 20) begin
          @(negedge clk);
          t++;
        end
        if (t >= 20) chk("stair_start_timeout", 64'(out_valid), 64'(stair[0]));
        for (int j = 0; j < 7; j++) begin
          chk($sformatf("stair_valid_%0d", j), 64'(out_valid), 64'(stair[j]));
          chk($sformatf("stair_done_%0d", j), 64'(done), 64'(j == 6));
          if (j == skew(2)) chk("lane2_first", 64'(out_data[2*DW +: DW]), 64'h0900);
          if (j == skew(2) + 1) chk("lane2_second", 64'(out_data[2*DW +: DW]), 64'h0A00);
          if (j < 6) @(negedge clk);
        end
      end
    join
    wait_idle();

    // stall mid-stream for 3 cycles with the third column held
    send_tile(16'h0010, 2, 3, fw, fd);
    wait_idle();

    // single-column tile of -1.0
    send_beat({N{16'hFF00}}, 1'b1, 0, fw, fd);
    @(negedge clk);
    chk("single_busy", 64'(busy), 64'd1);
    wait_idle();

    // back-to-back tiles
    send_tile(16'h0020, -1, 0, fw, fd);
    send_tile(16'h0030, -1, 0, fw, fd);
    chk("b2b_ready_low_cycles", 64'(fw), 64'd3);
    chk("b2b_done_at_accept", 64'(fd), 64'd1);
    wait_idle();

    // reset after 2 of 4 beats
    send_beat(col(16'h0040, 0), 1'b0, 0, fw, fd);
    send_beat(col(16'h0040, 1), 1'b0, 0, fw, fd);
    rst_n = 1'b0;
    flush_exp();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    flush_exp();
    send_tile(16'h0050, -1, 0, fw, fd);
    chk("post_rst_first_wait", 64'(fw), 64'd0);
    wait_idle();

    for (int i = 0; i < N; i++) chk($sformatf("lane%0d_leftover", i), 64'(exp_q[i].size()), 64'd0);
    chk("done_leftover", 64'(done_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
